// File: rtl/fpga_config_loader_if.sv
// fpga_config_loader_if: configuration word stream from bitstream source to loader.
interface fpga_config_loader_if;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: streams LUT tables, switch-box words and packed LUT bit32 into the fabric.
// LUT words are buffered because their bit 32 arrives in the final word.
module fpga_config_loader #(
    parameter int N_LUT = 8,
    parameter int N_SB  = 7,
    parameter int IDX_W = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    fpga_config_loader_if.slave    cfg,
    output logic                   lut_we_o,
    output logic [IDX_W-1:0]       lut_sel_o,
    output logic [32:0]            lut_data_o,
    output logic                   sb_we_o,
    output logic [IDX_W-1:0]       sb_sel_o,
    output logic [31:0]            sb_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   fabric_en_o
);
    localparam int N_WORDS = N_LUT + N_SB + 1;
    localparam int CNT_W   = $clog2(N_WORDS + 1);
    localparam int BUF_W   = $clog2(N_LUT);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             lut_we_q;
    logic [IDX_W-1:0] lut_sel_q;
    logic [32:0]      lut_data_q;
    logic             sb_we_q;
    logic [IDX_W-1:0] sb_sel_q;
    logic [31:0]      sb_data_q;
    logic             busy_q;
    logic             done_q;
    logic             fabric_en_q;
    logic [31:0]      bit32_q;
    logic [31:0]      lut_buf_q [N_LUT];
    logic             accept;
    logic [IDX_W-1:0] sel_d;

    assign accept = (state_q == LOAD) && ready_q && cfg.cfg_valid;
    assign sel_d  = lut_sel_q + IDX_W'(1);

    // Table storage has no reset; contents are only read after a full load.
    always_ff @(posedge clock_i) begin
        if (accept && !abort_i && cnt_q < CNT_W'(N_LUT))
            lut_buf_q[cnt_q[BUF_W-1:0]] <= cfg.cfg_data;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            lut_we_q    <= 1'b0;
            lut_sel_q   <= '0;
            lut_data_q  <= '0;
            sb_we_q     <= 1'b0;
            sb_sel_q    <= '0;
            sb_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fabric_en_q <= 1'b0;
            bit32_q     <= '0;
        end else begin
            sb_we_q <= 1'b0;
            done_q  <= 1'b0;
            if (abort_i) begin
                state_q     <= IDLE;
                ready_q     <= 1'b0;
                lut_we_q    <= 1'b0;
                busy_q      <= 1'b0;
                fabric_en_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start_i) begin
                        state_q     <= LOAD;
                        cnt_q       <= '0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        fabric_en_q <= 1'b0;
                    end
                    LOAD: if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q >= CNT_W'(N_LUT) && cnt_q < CNT_W'(N_LUT + N_SB)) begin
                            sb_we_q   <= 1'b1;
                            sb_sel_q  <= IDX_W'(cnt_q - CNT_W'(N_LUT));
                            sb_data_q <= cfg.cfg_data;
                        end else if (cnt_q == CNT_W'(N_WORDS - 1)) begin
                            // Bit-reversed so LUT j finds its bit32 at index j.
                            bit32_q    <= {<<{cfg.cfg_data}};
                            state_q    <= COMMIT;
                            ready_q    <= 1'b0;
                            lut_we_q   <= 1'b1;
                            lut_sel_q  <= '0;
                            lut_data_q <= {cfg.cfg_data[31], lut_buf_q[0]};
                        end
                    end
                    COMMIT: if (lut_sel_q == IDX_W'(N_LUT - 1)) begin
                        state_q     <= IDLE;
                        lut_we_q    <= 1'b0;
                        done_q      <= 1'b1;
                        fabric_en_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        lut_sel_q  <= sel_d;
                        lut_data_q <= {bit32_q[5'(sel_d)], lut_buf_q[sel_d[BUF_W-1:0]]};
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign lut_we_o      = lut_we_q;
    assign lut_sel_o     = lut_sel_q;
    assign lut_data_o    = lut_data_q;
    assign sb_we_o       = sb_we_q;
    assign sb_sel_o      = sb_sel_q;
    assign sb_data_o     = sb_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign fabric_en_o   = fabric_en_q;
endmodule
